// File: rtl/ratio_clk_pkg.sv
// Shared types and helpers for the ratio clock controller.
// Holds the state encoding, the watchdog width function and the ramp direction constants.
package ratio_clk_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_SLEW = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    localparam logic STEP_UP = 1'b1;
    localparam logic STEP_DN = 1'b0;

    // Wide enough to count one full generated-clock period at the slowest ratio.
    function automatic int wdog_w(input int rg);
        return (2 ** rg) + 1;
    endfunction

endpackage

// File: rtl/ratio_clk_edge_det.sv
// Falling-edge detector for the generated clock fed back on ratio_clk_i.
// Also hosts the watchdog counter, which restarts on every fall or on an external clear.
module ratio_clk_edge_det #(
    parameter int WDOG_W = 9
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic ratio_clk_i,
    input  logic wdog_clr,
    input  logic wdog_run,
    output logic fall,
    output logic wdog_tc
);

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = {1'b1, {(WDOG_W-1){1'b0}}};
    localparam logic [WDOG_W-1:0] WDOG_ONE   = {{(WDOG_W-1){1'b0}}, 1'b1};

    logic              clk_q;
    logic [WDOG_W-1:0] wdog;

    assign fall    = clk_q & ~ratio_clk_i;
    assign wdog_tc = (wdog == WDOG_LIMIT);

    // Saturates at the limit so a late reaction by the FSM can never wrap it.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            clk_q <= 1'b0;
            wdog  <= '0;
        end else begin
            clk_q <= ratio_clk_i;
            if (wdog_clr || fall || !wdog_run)
                wdog <= '0;
            else if (wdog != WDOG_LIMIT)
                wdog <= wdog + WDOG_ONE;
        end
    end

endmodule

// File: rtl/ratio_clk_ctrl.sv
// Upstream controller for the ratio clock generator: accepts en/ratio requests and
// applies them only at safe points of the generated clock, optionally ramping the ratio.
//
// state | meaning
// OFF   | generator disabled, ready for a request
// RUN   | generator running at ratio_o, ready for a request
// SLEW  | moving ratio_o toward the target on generated-clock falls
// STOP  | waiting for the generated clock to be low before disabling
module ratio_clk_ctrl
    import ratio_clk_pkg::*;
#(
    parameter int                     RATIO_GRADE = 3,
    parameter bit                     STEP_MODE   = 1'b1,
    parameter logic [RATIO_GRADE-1:0] RESET_RATIO = '0
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_en_i,
    input  logic [RATIO_GRADE-1:0] req_ratio_i,
    input  logic                   ratio_clk_i,
    output logic                   en_o,
    output logic [RATIO_GRADE-1:0] ratio_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   timeout_o
);

    localparam int                     WDOG_W    = wdog_w(RATIO_GRADE);
    localparam logic [RATIO_GRADE-1:0] RATIO_ONE = {{(RATIO_GRADE-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [RATIO_GRADE-1:0]   tgt_ratio_q;
    logic [RATIO_GRADE-1:0]   ratio_d, step_val;
    logic                     en_d, apply_d, tmo_d;
    logic                     done_p, tmo_p;
    logic                     accept, fall, wdog_tc, wdog_clr, wdog_run, step_dir;

    assign accept   = req_valid_i & req_ready_o;
    assign wdog_clr = (state_d != state_q);
    assign wdog_run = (state_q == ST_SLEW) || (state_q == ST_STOP);
    assign step_dir = (tgt_ratio_q > ratio_o) ? STEP_UP : STEP_DN;

    ratio_clk_edge_det #(.WDOG_W(WDOG_W)) u_edge_det (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .ratio_clk_i (ratio_clk_i),
        .wdog_clr    (wdog_clr),
        .wdog_run    (wdog_run),
        .fall        (fall),
        .wdog_tc     (wdog_tc)
    );

    // Compare before stepping so the ramp can neither overshoot nor wrap.
    always_comb begin
        step_val = tgt_ratio_q;
        if (STEP_MODE && (tgt_ratio_q != ratio_o))
            step_val = (step_dir == STEP_UP) ? ratio_o + RATIO_ONE : ratio_o - RATIO_ONE;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            state_q <= ST_OFF;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:  if (accept && req_en_i) state_d = ST_RUN;
            ST_RUN:  if (accept) begin
                         if (!req_en_i)
                             state_d = ST_STOP;
                         else if (req_ratio_i != ratio_o)
                             state_d = ST_SLEW;
                     end
            ST_SLEW: if (fall) begin
                         if (step_val == tgt_ratio_q) state_d = ST_RUN;
                     end else if (wdog_tc) begin
                         state_d = ST_RUN;
                     end
            ST_STOP: if (!ratio_clk_i || wdog_tc) state_d = ST_OFF;
            default: state_d = ST_OFF;
        endcase
    end

    always_comb begin
        en_d    = en_o;
        ratio_d = ratio_o;
        apply_d = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            ST_OFF:  if (accept) begin
                         en_d    = req_en_i;
                         ratio_d = req_ratio_i;
                         apply_d = 1'b1;
                     end
            ST_RUN:  if (accept && req_en_i && (req_ratio_i == ratio_o)) apply_d = 1'b1;
            ST_SLEW: if (fall) begin
                         ratio_d = step_val;
                         apply_d = (step_val == tgt_ratio_q);
                     end else if (wdog_tc) begin
                         ratio_d = tgt_ratio_q;
                         apply_d = 1'b1;
                         tmo_d   = 1'b1;
                     end
            ST_STOP: if (!ratio_clk_i || wdog_tc) begin
                         en_d    = 1'b0;
                         ratio_d = tgt_ratio_q;
                         apply_d = 1'b1;
                         tmo_d   = ratio_clk_i;
                     end
            default: ;
        endcase
    end

    // done/timeout trail the output update by one cycle so they mark a settled value.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            en_o        <= 1'b0;
            ratio_o     <= RESET_RATIO;
            tgt_ratio_q <= RESET_RATIO;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_p      <= 1'b0;
            tmo_p       <= 1'b0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            en_o        <= en_d;
            ratio_o     <= ratio_d;
            if (accept)
                tgt_ratio_q <= req_ratio_i;
            req_ready_o <= (state_d == ST_OFF) || (state_d == ST_RUN);
            busy_o      <= (state_d == ST_SLEW) || (state_d == ST_STOP);
            done_p      <= apply_d;
            tmo_p       <= tmo_d;
            done_o      <= done_p;
            timeout_o   <= tmo_p;
        end
    end

endmodule

// File: tb/tb_ratio_clk_ctrl.sv
// Directed bench for ratio_clk_ctrl, each instance paired with a behavioural ratio clock generator.
// dut0 ramps (STEP_MODE=1), dut1 jumps (STEP_MODE=0).
module tb_ratio_clk_ctrl;

    localparam int RG = 3;

    logic clk_i = 1'b0;
    logic arst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          req_en;
    logic [RG-1:0] req_ratio;
    logic          valid0, valid1, stuck0;
    logic          ready0, en0, busy0, done0, tmo0;
    logic          ready1, en1, busy1, done1, tmo1;
    logic [RG-1:0] ratio0, ratio1;
    logic          gen0, gen1, fb0;
    logic [7:0]    gcnt0, gcnt1;

    int n_err = 0;
    int n_chk = 0;
    logic [RG-1:0] seen[$];

    assign fb0 = gen0 | stuck0;

    ratio_clk_ctrl #(.RATIO_GRADE(RG), .STEP_MODE(1'b1), .RESET_RATIO(3'd0)) dut0 (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .req_valid_i(valid0), .req_ready_o(ready0),
        .req_en_i(req_en), .req_ratio_i(req_ratio), .ratio_clk_i(fb0), .en_o(en0),
        .ratio_o(ratio0), .busy_o(busy0), .done_o(done0), .timeout_o(tmo0)
    );

    ratio_clk_ctrl #(.RATIO_GRADE(RG), .STEP_MODE(1'b0), .RESET_RATIO(3'd0)) dut1 (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .req_valid_i(valid1), .req_ready_o(ready1),
        .req_en_i(req_en), .req_ratio_i(req_ratio), .ratio_clk_i(gen1), .en_o(en1),
        .ratio_o(ratio1), .busy_o(busy1), .done_o(done1), .timeout_o(tmo1)
    );

    // Generator model: half-period of 2**ratio clk_i cycles, held low while disabled.
    always @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin gen0 <= 1'b0; gcnt0 <= '0; end
        else if (!en0) begin gen0 <= 1'b0; gcnt0 <= '0; end
        else if (gcnt0 >= (8'd1 << ratio0) - 8'd1) begin gen0 <= ~gen0; gcnt0 <= '0; end
        else gcnt0 <= gcnt0 + 8'd1;
    end

    always @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin gen1 <= 1'b0; gcnt1 <= '0; end
        else if (!en1) begin gen1 <= 1'b0; gcnt1 <= '0; end
        else if (gcnt1 >= (8'd1 << ratio1) - 8'd1) begin gen1 <= ~gen1; gcnt1 <= '0; end
        else gcnt1 <= gcnt1 + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Waits for ready, presents the request for exactly the accepting edge.
    task automatic req(input int sel, input logic en, input logic [RG-1:0] r);
        int k;
        k = 0;
        req_en = en;
        req_ratio = r;
        while (((sel == 0) ? ready0 : ready1) !== 1'b1 && k < 1000) begin
            tick();
            k++;
        end
        chk("req_ready_wait", (k < 1000), 1);
        if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
        tick();
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    // Records every ratio_o change until done_o, bounded by max cycles.
    task automatic watch(input int sel, input int max, output int ncyc);
        logic [RG-1:0] prev, cur;
        logic d;
        seen.delete();
        prev = (sel == 0) ? ratio0 : ratio1;
        d = (sel == 0) ? done0 : done1;
        ncyc = 0;
        while (d !== 1'b1 && ncyc < max) begin
            tick();
            ncyc++;
            cur = (sel == 0) ? ratio0 : ratio1;
            if (cur != prev) seen.push_back(cur);
            prev = cur;
            d = (sel == 0) ? done0 : done1;
        end
        chk("done_seen", d, 1);
    endtask

    // Length in clk_i cycles of the next complete high phase of dut0's feedback.
    task automatic high_len(input int max, output int n);
        int k;
        k = 0;
        n = 0;
        while (fb0 === 1'b1 && k < max) begin tick(); k++; end
        while (fb0 === 1'b0 && k < max) begin tick(); k++; end
        while (fb0 === 1'b1 && k < max) begin n++; tick(); k++; end
        chk("high_len_bound", (k < max), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int nc, hc, k;
        logic early;
        req_en = 1'b0; req_ratio = '0;
        valid0 = 1'b0; valid1 = 1'b0; stuck0 = 1'b0;
        repeat (3) tick();
        arst_n_i = 1'b1;
        tick();

        chk("rst_ready", ready0, 1);
        chk("rst_en", en0, 0);
        chk("rst_ratio", ratio0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_timeout", tmo0, 0);

        // OFF -> RUN at ratio 2
        req(0, 1'b1, 3'd2);
        chk("t1_en", en0, 1);
        chk("t1_ratio", ratio0, 2);
        chk("t1_done_early", done0, 0);
        chk("t1_ready", ready0, 1);
        tick();
        chk("t1_done", done0, 1);
        tick();
        chk("t1_done_width", done0, 0);
        high_len(200, hc);
        chk("t1_half_period", hc, 4);

        // Ramp 2 -> 5
        req(0, 1'b1, 3'd5);
        chk("t2_busy", busy0, 1);
        chk("t2_ready", ready0, 0);
        watch(0, 2000, nc);
        chk("t2_steps", seen.size(), 3);
        chk("t2_step0", seen[0], 3);
        chk("t2_step1", seen[1], 4);
        chk("t2_step2", seen[2], 5);
        chk("t2_busy_end", busy0, 0);
        tick();
        chk("t2_done_width", done0, 0);
        high_len(300, hc);
        chk("t2_half_period", hc, 32);

        // Stop: en_o drops only after a complete high phase
        k = 0;
        while (fb0 === 1'b1 && k < 200) begin tick(); k++; end
        while (fb0 === 1'b0 && k < 200) begin tick(); k++; end
        hc = 1;
        tick(); if (fb0) hc++;
        tick(); if (fb0) hc++;
        req(0, 1'b0, 3'd0);
        if (fb0) hc++;
        chk("t4_busy", busy0, 1);
        early = 1'b0;
        k = 0;
        while (fb0 === 1'b1 && k < 100) begin
            if (!en0) early = 1'b1;
            tick();
            k++;
            if (fb0) hc++;
        end
        chk("t4_en_held", early, 0);
        chk("t4_full_high", hc, 32);
        tick();
        chk("t4_en_off", en0, 0);
        chk("t4_ratio", ratio0, 0);
        tick();
        chk("t4_done", done0, 1);
        chk("t4_ready", ready0, 1);
        chk("t4_busy_end", busy0, 0);

        // Jump mode 1 -> 6 on dut1
        req(1, 1'b1, 3'd1);
        watch(1, 20, nc);
        chk("t3_start_ratio", ratio1, 1);
        req(1, 1'b1, 3'd6);
        watch(1, 200, nc);
        chk("t3_changes", seen.size(), 1);
        chk("t3_jump", seen[0], 6);
        tick();
        chk("t3_done_width", done1, 0);

        // Watchdog: feedback stuck high during a ramp 1 -> 4
        req(0, 1'b1, 3'd1);
        watch(0, 20, nc);
        stuck0 = 1'b1;
        repeat (3) tick();
        req(0, 1'b1, 3'd4);
        watch(0, 400, nc);
        // count clears at accept, saturates 256 cycles later; apply, then done one cycle after
        chk("t5_latency", nc, 258);
        chk("t5_timeout", tmo0, 1);
        chk("t5_ratio", ratio0, 4);
        chk("t5_changes", seen.size(), 1);
        tick();
        chk("t5_timeout_width", tmo0, 0);

        // Ramp down 4 -> 2 with feedback restored
        stuck0 = 1'b0;
        req(0, 1'b1, 3'd2);
        watch(0, 2000, nc);
        chk("dn_steps", seen.size(), 2);
        chk("dn_step0", seen[0], 3);
        chk("dn_step1", seen[1], 2);
        chk("dn_timeout", tmo0, 0);

        // Reset during SLEW, with a request held while not ready
        req(0, 1'b1, 3'd0);
        tick();
        chk("t6_busy", busy0, 1);
        req_en = 1'b1;
        req_ratio = 3'd7;
        valid0 = 1'b1;
        repeat (3) tick();
        chk("t6_not_ready", ready0, 0);
        chk("t6_not_taken", (ratio0 != 3'd7), 1);
        arst_n_i = 1'b0;
        #1;
        chk("t6_en", en0, 0);
        chk("t6_ratio", ratio0, 0);
        chk("t6_ready", ready0, 1);
        chk("t6_busy_clr", busy0, 0);
        valid0 = 1'b0;
        repeat (2) tick();
        arst_n_i = 1'b1;
        repeat (4) tick();
        chk("t6_post_en", en0, 0);
        chk("t6_post_ratio", ratio0, 0);
        chk("t6_post_ready", ready0, 1);
        chk("t6_post_done", done0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
